cla_nibble_subtractor: RTL and testbench

- Multi-cycle unsigned subtractor computing DIFF = A - B - BIN over WIDTH bits.
- Processes one 4-bit nibble per clock, least significant first, using a 4-bit borrow-lookahead slice (A + ~B + ~borrow with generate/propagate carries).
- The borrow is registered between nibbles, so wide operands cost area for one slice only.
- Sits beside the 4-bit lookahead adders in the arithmetic library, as their subtract-direction counterpart, with a valid/ready front end and back end.

---
 rtl/cla_nibble_subtractor.sv | 129 ++++++++++++
 tb/tb_cla_nibble_subtractor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b - bin, one 4-bit borrow-lookahead
// slice reused per nibble (LSB first) with the borrow registered between nibbles.
module cla_nibble_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    // state  | meaning
    // IDLE   | ready for operands, previous result held on diff/borrow/zero
    // RUN    | one nibble per edge, LSB first, borrow carried in r_brw
    // DONE   | result valid, held until out_ready
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_brw;
    logic             r_borrow;
    logic             r_zero;

    logic [CW+1:0]    w_lo;
    logic [3:0]       w_an;
    logic [3:0]       w_bn;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic [4:0]       w_c;
    logic [3:0]       w_dnib;
    logic [WIDTH-1:0] w_diff_next;

    assign w_lo = {r_cnt, 2'b00};
    assign w_an = r_a[w_lo +: 4];
    assign w_bn = ~r_b[w_lo +: 4];
    assign w_g  = w_an & w_bn;
    assign w_p  = w_an ^ w_bn;

    // Subtraction as a + ~b + carry, where carry-in is the inverted running borrow.
    assign w_c[0] = ~r_brw;
    assign w_c[1] = w_g[0]
                  | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1]
                  | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2]
                  | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3]
                  | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign w_dnib = w_p ^ w_c[3:0];

    // Full result including the nibble being written this edge, for the zero flag.
    always_comb begin
        w_diff_next             = r_diff;
        w_diff_next[w_lo +: 4]  = w_dnib;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_brw    <= 1'b0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_brw   <= bin;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_diff <= w_diff_next;
                    r_brw  <= ~w_c[4];
                    if (r_cnt == LAST) begin
                        r_borrow <= ~w_c[4];
                        r_zero   <= (w_diff_next == '0);
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign zero      = r_zero;

endmodule

// File: tb/tb_cla_nibble_subtractor.sv
// Scoreboard bench for cla_nibble_subtractor: driver pushes arithmetic reference
// results, a monitor pops and compares them whenever out_valid is presented.
module tb_cla_nibble_subtractor;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    typedef struct {
        logic [WIDTH:0] res;
        int             acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a_i = '0;
    logic [WIDTH-1:0] b_i = '0;
    logic             bin_i = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   stall = 0;
    bit   rand_rdy = 1'b0;
    bit   seen = 1'b0;
    exp_t cur;
    exp_t sb[$];

    cla_nibble_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .bin       (bin_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tbin);
        int   guard = 0;
        exp_t e;
        @(negedge clk);
        a_i      = ta;
        b_i      = tb_;
        bin_i    = tbin;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
            in_valid = 1'b0;
            return;
        end
        e.res = {1'b0, ta} - {1'b0, tb_} - (WIDTH+1)'(tbin);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Monitor / scoreboard consumer
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen      = 1'b0;
                out_ready = 1'b0;
            end else if (out_valid) begin
                chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
                if (!seen) begin
                    seen = 1'b1;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: diff=0x%0h with empty scoreboard", diff);
                        cur.res = {borrow, diff};
                        cur.acc = cyc - NIB;
                    end else begin
                        cur = sb.pop_front();
                        chk("latency", 32'(cyc - cur.acc), 32'(NIB));
                    end
                end
                chk("diff",   32'(diff),   32'(cur.res[WIDTH-1:0]));
                chk("borrow", 32'(borrow), 32'(cur.res[WIDTH]));
                chk("zero",   32'(zero),   32'(cur.res[WIDTH-1:0] == '0));
                if (stall > 0) begin
                    out_ready = 1'b0;
                    stall--;
                end else begin
                    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end else begin
                seen      = 1'b0;
                out_ready = 1'b0;
            end
        end
    end

    initial begin
        int guard;
        logic [WIDTH-1:0] ra, rb;

        #2;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff",      32'(diff),      32'd0);
        chk("rst_borrow",    32'(borrow),    32'd0);
        chk("rst_zero",      32'(zero),      32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        issue(16'h1234, 16'h0234, 1'b0);
        issue(16'h1000, 16'h0001, 1'b0);
        issue(16'h0000, 16'h0001, 1'b0);
        issue(16'h0001, 16'h0000, 1'b1);
        issue(16'h0000, 16'h0000, 1'b1);
        issue(16'hFFFF, 16'hFFFF, 1'b1);
        issue(16'h5A5A, 16'h5A5A, 1'b0);

        // Backpressure: new operands wait on in_valid while the result is held.
        issue(16'hABCD, 16'hABCD, 1'b0);
        stall = 5;
        issue(16'h5555, 16'h1111, 1'b0);

        // Abort in the second cycle of RUN.
        issue(16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_diff",      32'(diff),      32'd0);
        chk("abort_borrow",    32'(borrow),    32'd0);
        chk("abort_zero",      32'(zero),      32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_abort_in_ready", 32'(in_ready),  32'd1);
        chk("post_abort_idle",     32'(out_valid), 32'd0);
        issue(16'h8000, 16'h0001, 1'b0);

        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : WIDTH'($urandom);
            issue(ra, rb, 1'($urandom_range(0, 1)));
        end

        guard = 0;
        while ((sb.size() != 0 || out_valid) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
